// File: rtl/motor_avoid_ctrl.sv
// ============================================================================
// motor_avoid_ctrl : obstacle-avoidance H-bridge controller with internal PWM
// Optional feature macro: TURN_ALTERNATE_EN (alternate left/right turns)
// Revision: 1.0
// ============================================================================
`default_nettype none

module motor_avoid_ctrl #(
    parameter int DIST_W    = 20,
    parameter int STOP_DIST = 25,
    parameter int CNT_W     = 27,
    parameter int BRAKE_CYC = 80000,
    parameter int REV_CYC   = 180000,
    parameter int TURN_CYC  = 240000,
    parameter int PWM_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DIST_W-1:0] i_dist,
    input  logic              i_dist_valid,
    input  logic [PWM_W-1:0]  i_duty,
    output logic [3:0]        o_motor,
    output logic [2:0]        o_state,
    output logic [7:0]        o_avoid_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CRUISE  = 3'd1,
        S_BRAKE   = 3'd2,
        S_REVERSE = 3'd3,
        S_TURN    = 3'd4
    } state_t;

    localparam logic [DIST_W-1:0] c_STOP_DIST  = DIST_W'(STOP_DIST);
    localparam logic [CNT_W-1:0]  c_BRAKE_LAST = CNT_W'(BRAKE_CYC - 1);
    localparam logic [CNT_W-1:0]  c_REV_LAST   = CNT_W'(REV_CYC - 1);
    localparam logic [CNT_W-1:0]  c_TURN_LAST  = CNT_W'(TURN_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_phase;
    logic [CNT_W-1:0]  w_phase_last;
    logic              w_phase_done;
    logic              w_turn_done;
    logic              w_turn_right;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [PWM_W-1:0]  r_duty_lat;
    logic [PWM_W-1:0]  w_duty_eff;
    logic              w_pwm;
    logic [3:0]        r_motor;
    logic [3:0]        w_motor_nxt;
    logic [7:0]        r_avoid_cnt;

    // Duty takes effect from the very first count of the period it is latched in
    assign w_duty_eff = (r_pwm_cnt == '0) ? i_duty : r_duty_lat;
    assign w_pwm      = (r_pwm_cnt < w_duty_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt  <= '0;
            r_duty_lat <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == '0) begin
                r_duty_lat <= i_duty;
            end
        end
    end

    always_comb begin
        w_phase_last = '0;
        case (r_state)
            S_BRAKE:   w_phase_last = c_BRAKE_LAST;
            S_REVERSE: w_phase_last = c_REV_LAST;
            S_TURN:    w_phase_last = c_TURN_LAST;
            default:   w_phase_last = '0;
        endcase
    end

    assign w_phase_done = (r_phase == w_phase_last);

    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_CRUISE;
                S_CRUISE:  if (i_dist_valid && (i_dist <= c_STOP_DIST)) w_state_nxt = S_BRAKE;
                S_BRAKE:   if (w_phase_done) w_state_nxt = S_REVERSE;
                S_REVERSE: if (w_phase_done) w_state_nxt = S_TURN;
                S_TURN:    if (w_phase_done) w_state_nxt = S_CRUISE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_turn_done = (r_state == S_TURN) && (w_state_nxt == S_CRUISE);

    // Phase counter only runs in timed states and always exits before wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_avoid_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_phase <= '0;
            end else if ((r_state == S_BRAKE) || (r_state == S_REVERSE) || (r_state == S_TURN)) begin
                r_phase <= r_phase + 1'b1;
            end
            if (w_turn_done && (r_avoid_cnt != 8'hFF)) begin
                r_avoid_cnt <= r_avoid_cnt + 8'd1;
            end
        end
    end

`ifdef TURN_ALTERNATE_EN
    logic r_turn_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_turn_right <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_turn_right <= 1'b0;
        end else if (w_turn_done) begin
            r_turn_right <= ~r_turn_right;
        end
    end

    assign w_turn_right = r_turn_right;
`else
    assign w_turn_right = 1'b0;
`endif

    always_comb begin
        w_motor_nxt = 4'b0000;
        case (r_state)
            S_CRUISE:  w_motor_nxt = {w_pwm, 1'b0, 1'b0, w_pwm};
            S_REVERSE: w_motor_nxt = {1'b0, w_pwm, w_pwm, 1'b0};
            S_TURN:    w_motor_nxt = w_turn_right ? {w_pwm, 1'b0, w_pwm, 1'b0}
                                                  : {1'b0, w_pwm, 1'b0, w_pwm};
            default:   w_motor_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_motor <= 4'b0000;
        end else begin
            r_motor <= w_motor_nxt;
        end
    end

    assign o_motor     = r_motor;
    assign o_state     = r_state;
    assign o_avoid_cnt = r_avoid_cnt;

    // Both legs of one half-bridge high at once would short the supply
    a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n)
        !(o_motor[3] && o_motor[2]) && !(o_motor[1] && o_motor[0]));

endmodule

`default_nettype wire

// File: tb/tb_motor_avoid_ctrl.sv
// ============================================================================
// tb_motor_avoid_ctrl : directed self-checking bench for motor_avoid_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_motor_avoid_ctrl;

    localparam int BRAKE_CYC = 4;
    localparam int REV_CYC   = 6;
    localparam int TURN_CYC  = 8;

`ifdef TURN_ALTERNATE_EN
    localparam logic [3:0] c_TURN2 = 4'b1010;
`else
    localparam logic [3:0] c_TURN2 = 4'b0101;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_en;
    logic [19:0] r_dist;
    logic        r_dist_valid;
    logic [7:0]  r_duty;
    logic [3:0]  w_motor;
    logic [2:0]  w_state;
    logic [7:0]  w_avoid;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_shoot = 0;

    always #5 clk = ~clk;

    motor_avoid_ctrl #(
        .DIST_W    (20),
        .STOP_DIST (25),
        .CNT_W     (8),
        .BRAKE_CYC (BRAKE_CYC),
        .REV_CYC   (REV_CYC),
        .TURN_CYC  (TURN_CYC),
        .PWM_W     (8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (r_en),
        .i_dist       (r_dist),
        .i_dist_valid (r_dist_valid),
        .i_duty       (r_duty),
        .o_motor      (w_motor),
        .o_state      (w_state),
        .o_avoid_cnt  (w_avoid)
    );

    always @(negedge clk) begin
        if (rst_n && ((w_motor[3] && w_motor[2]) || (w_motor[1] && w_motor[0]))) n_shoot++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic trigger(input logic [19:0] d);
        r_dist       = d;
        r_dist_valid = 1'b1;
        @(negedge clk);
        r_dist_valid = 1'b0;
    endtask

    // Counts samples spent in a state and ORs the motor bus (skipping the first,
    // which still shows the previous state's drive)
    task automatic measure(input string tag, input logic [2:0] code, input int exp_len,
                           input logic [3:0] exp_or, input bit strobe);
        int         n   = 0;
        logic [3:0] acc = 4'b0000;
        while (w_state == code && n < 1000) begin
            if (n > 0) acc = acc | w_motor;
            if (strobe) begin
                r_dist       = 20'd5;
                r_dist_valid = 1'b1;
            end
            n++;
            step(1);
        end
        r_dist_valid = 1'b0;
        check_val({tag, "_len"}, 32'(n), 32'(exp_len));
        check_val({tag, "_mot"}, 32'(acc), 32'(exp_or));
    endtask

    task automatic manoeuvre(input string tag, input logic [19:0] d, input logic [3:0] turn_pat,
                             input bit pwm_on, input bit strobe);
        trigger(d);
        measure({tag, "_brake"}, 3'd2, BRAKE_CYC, 4'b0000, 1'b0);
        measure({tag, "_rev"}, 3'd3, REV_CYC, pwm_on ? 4'b0110 : 4'b0000, strobe);
        measure({tag, "_turn"}, 3'd4, TURN_CYC, pwm_on ? turn_pat : 4'b0000, 1'b0);
        check_val({tag, "_cruise"}, 32'(w_state), 32'd1);
    endtask

    task automatic quick();
        int n = 0;
        trigger(20'd25);
        while (w_state != 3'd1 && n < 100) begin
            n++;
            step(1);
        end
        check_val("quick_len", 32'(n), 32'(BRAKE_CYC + REV_CYC + TURN_CYC));
    endtask

    task automatic count_pwm(input string tag, input int exp_on);
        int on  = 0;
        int off = 0;
        repeat (256) begin
            if (w_motor == 4'b1001) on++;
            else if (w_motor == 4'b0000) off++;
            step(1);
        end
        check_val({tag, "_on"}, 32'(on), 32'(exp_on));
        check_val({tag, "_off"}, 32'(off), 32'(256 - exp_on));
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        r_en         = 1'b0;
        r_dist       = '0;
        r_dist_valid = 1'b0;
        r_duty       = '0;
        step(3);
        check_val("rst_state", 32'(w_state), 32'd0);
        check_val("rst_motor", 32'(w_motor), 32'd0);
        check_val("rst_avoid", 32'(w_avoid), 32'd0);
        rst_n = 1'b1;
        step(1);
        check_val("idle_hold", 32'(w_state), 32'd0);
        r_en = 1'b1;
        step(1);
        check_val("cruise_entry", 32'(w_state), 32'd1);

        r_duty = 8'd255;
        step(300);
        count_pwm("duty255", 255);
        r_duty = 8'd128;
        step(300);
        count_pwm("duty128", 128);

        r_duty = 8'd255;
        step(300);
        r_dist = 20'd10;
        step(3);
        check_val("no_valid", 32'(w_state), 32'd1);
        trigger(20'd26);
        step(1);
        check_val("dist26", 32'(w_state), 32'd1);

        manoeuvre("m1", 20'd25, 4'b0101, 1'b1, 1'b1);
        check_val("m1_avoid", 32'(w_avoid), 32'd1);
        manoeuvre("m2", 20'd5, c_TURN2, 1'b1, 1'b0);
        check_val("m2_avoid", 32'(w_avoid), 32'd2);
        manoeuvre("m3", 20'd0, 4'b0101, 1'b1, 1'b0);
        check_val("m3_avoid", 32'(w_avoid), 32'd3);

        trigger(20'd25);
        measure("m4_brake", 3'd2, BRAKE_CYC, 4'b0000, 1'b0);
        step(2);
        check_val("m4_in_rev", 32'(w_state), 32'd3);
        r_en = 1'b0;
        step(1);
        check_val("abort_idle", 32'(w_state), 32'd0);
        step(1);
        check_val("abort_motor", 32'(w_motor), 32'd0);
        r_en = 1'b1;
        step(1);
        check_val("reenter_cruise", 32'(w_state), 32'd1);
        check_val("abort_avoid", 32'(w_avoid), 32'd3);

        // Turn direction must restart at left after passing through IDLE
        manoeuvre("m5", 20'd25, 4'b0101, 1'b1, 1'b0);
        check_val("m5_avoid", 32'(w_avoid), 32'd4);

        repeat (250) quick();
        check_val("avoid_254", 32'(w_avoid), 32'd254);
        quick();
        check_val("avoid_255", 32'(w_avoid), 32'd255);
        quick();
        check_val("avoid_sat", 32'(w_avoid), 32'd255);

        r_duty = 8'd0;
        step(300);
        manoeuvre("d0", 20'd25, 4'b0101, 1'b0, 1'b0);
        step(2);
        check_val("d0_cruise_motor", 32'(w_motor), 32'd0);

        r_duty = 8'd255;
        step(300);
        trigger(20'd25);
        n = 0;
        while (w_state != 3'd4 && n < 100) begin
            n++;
            step(1);
        end
        check_val("pre_rst_turn", 32'(w_state), 32'd4);
        step(2);
        check_val("pre_rst_motor_on", 32'(w_motor != 4'b0000), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_state", 32'(w_state), 32'd0);
        check_val("async_motor", 32'(w_motor), 32'd0);
        check_val("async_avoid", 32'(w_avoid), 32'd0);
        check_val("shoot_through", 32'(n_shoot), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
